// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
// req is held until gnt; rvalid/rdata return load data in a later cycle.
interface mem_access_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: one bus transaction per load/store, byte-lane formatting, register write-back.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of ignoring the low address bits.
//
// state | meaning
// IDLE  | sampling exe outputs; ALU results written back with 1-cycle latency
// REQ   | dm_req held with stable command until dm_gnt
// WAIT  | load granted, waiting for dm_rvalid or timeout
module mem_access #(
    parameter int TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         write_reg,
    input  logic         load_en,
    input  logic         store_en,
    input  logic [2:0]   funct3,
    input  logic [4:0]   rd,
    input  logic [31:0]  addr,
    input  logic [31:0]  data,
    input  logic [31:0]  res,
    output logic         stall,
    mem_access_if.master dm,
    output logic         wb_en,
    output logic [4:0]   wb_rd,
    output logic [31:0]  wb_data,
    output logic         bus_err,
    output logic         misalign_exc
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] WAIT = 2'b10;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_st_q, is_st_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [2:0]    f3_q, f3_d;
    logic          wb_en_q, wb_en_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          bus_err_q, bus_err_d;

    logic          in_req;
    logic [3:0]    strb;
    logic [31:0]   wdata;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_val;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic misalign_in;
    assign misalign_in = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1] && addr[1:0] != 2'b00);
`endif

    // Lane selection uses the captured address so the command stays stable while REQ waits for gnt.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   begin strb = 4'b0001 << addr_q[1:0];        wdata = {4{data_q[7:0]}};  end
            2'b01:   begin strb = 4'b0011 << {addr_q[1], 1'b0};  wdata = {2{data_q[15:0]}}; end
            default: begin strb = 4'b1111;                       wdata = data_q;            end
        endcase
    end

    assign byte_v = dm.dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_v = dm.dm_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q[1:0])
            2'b00:   load_val = {{24{byte_v[7] & ~f3_q[2]}}, byte_v};
            2'b01:   load_val = {{16{half_v[15] & ~f3_q[2]}}, half_v};
            default: load_val = dm.dm_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_st_d   = is_st_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        f3_d      = f3_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        bus_err_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load_en || store_en) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misalign_in) misalign_d = 1'b1;
                    else
`endif
                    begin
                        is_st_d = store_en;
                        rd_d    = rd;
                        addr_d  = addr;
                        data_d  = data;
                        f3_d    = funct3;
                        state_d = REQ;
                    end
                end else begin
                    wb_en_d   = write_reg;
                    wb_rd_d   = rd;
                    wb_data_d = res;
                end
            end
            REQ: begin
                if (dm.dm_gnt) begin
                    state_d = is_st_q ? IDLE : WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (dm.dm_rvalid) begin
                    wb_en_d   = 1'b1;
                    wb_rd_d   = rd_q;
                    wb_data_d = load_val;
                    state_d   = IDLE;
                end else if (TIMEOUT != 0 && cnt_q == LAST) begin
                    bus_err_d = 1'b1;
                    wb_en_d   = 1'b1;
                    wb_rd_d   = rd_q;
                    wb_data_d = '0;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_st_q   <= 1'b0;
            rd_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            f3_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_st_q   <= is_st_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            f3_q      <= f3_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= misalign_d;
    end
    assign misalign_exc = misalign_q;
`else
    assign misalign_exc = 1'b0;
`endif

    assign in_req      = (state_q == REQ);
    assign stall       = (state_q != IDLE);
    assign dm.dm_req   = in_req;
    assign dm.dm_we    = in_req & is_st_q;
    assign dm.dm_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dm.dm_wstrb = (in_req && is_st_q) ? strb : 4'b0000;
    assign dm.dm_wdata = (in_req && is_st_q) ? wdata : 32'd0;
    assign wb_en       = wb_en_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign bus_err     = bus_err_q;
endmodule
